fifo_byte_serializer: RTL and testbench

Downstream drain stage for the 32-bit word FIFO. Pops one word at a time whenever the FIFO reports non-empty and emits it as four bytes on a valid/ready byte stream, marking the last byte of each word. Keeps a running count of fully transmitted words for status readback. Sits between the FIFO read port and any byte-wide consumer (UART TX, SPI shifter, debug port).

---
 rtl/fifo_byte_serializer.sv | 123 ++++++++++++
 tb/tb_fifo_byte_serializer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_byte_serializer.sv
// Purpose : drains 32-bit words from a FIFO read port and emits them as a valid/ready byte stream,
//           flagging the final byte of each word and counting fully transmitted words.
// Latency : fifo_rd at T, word captured at T+1, first byte valid at T+2; one bubble between back-to-back words.
// Backpr. : out_ready low holds the current byte stable in SEND; no FIFO reads happen while stalled.
//
// Ports:
//   clk, rst_n         single rising-edge clock, synchronous active-low reset
//   fifo_empty/fifo_rd FIFO status in / one-cycle read strobe out (never asserted while empty)
//   fifo_data          FIFO read data, valid the cycle after fifo_rd
//   out_data/out_valid/out_ready/out_last  byte stream, out_last marks the final byte of a word
//   busy               high in any state other than IDLE
//   word_count         words whose last byte was accepted (wraps silently)
module fifo_byte_serializer #(
  parameter int DATA_W    = 32,
  parameter int BYTE_W    = 8,
  parameter int MSB_FIRST = 0,
  parameter int CNT_W     = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              fifo_empty,
  output logic              fifo_rd,
  input  logic [DATA_W-1:0] fifo_data,
  output logic [BYTE_W-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy,
  output logic [CNT_W-1:0]  word_count
);

  // Beats per word and width of the byte index.
  localparam int N     = DATA_W / BYTE_W;
  localparam int IDX_W = (N > 1) ? $clog2(N) : 1;

  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(N - 1);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FETCH = 2'd1;
  localparam logic [1:0] S_SEND  = 2'd2;

  logic [1:0]                 state;
  logic [1:0]                 state_nxt;
  logic [DATA_W-1:0]          word_q;
  logic [N-1:0][BYTE_W-1:0]   word_bytes;
  logic [IDX_W-1:0]           idx;
  logic [IDX_W-1:0]           byte_sel;
  logic                       is_last;
  logic                       beat_ok;
  logic                       rd_req;

  assign is_last = (idx == LAST_IDX);
  assign beat_ok = (state == S_SEND) && out_ready;

  // A new word may be requested from IDLE, or in the very cycle the last
  // byte of the current word is accepted, which keeps the stream at one
  // bubble per word. Gating with rst_n and fifo_empty guarantees no read
  // strobe during reset and no FIFO underflow.
  assign rd_req  = (state == S_IDLE) || (beat_ok && is_last);
  assign fifo_rd = rst_n && !fifo_empty && rd_req;

  // Byte 0 is the least-significant lane of the captured word.
  assign word_bytes = word_q;
  assign byte_sel   = (MSB_FIRST != 0) ? (LAST_IDX - idx) : idx;

  always_comb begin
    out_data = '0;
    if (state == S_SEND) begin
      out_data = word_bytes[byte_sel];
    end
  end

  assign out_valid = (state == S_SEND);
  assign out_last  = (state == S_SEND) && is_last;
  assign busy      = (state != S_IDLE);

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE: begin
        if (fifo_rd) begin
          state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        state_nxt = S_SEND;
      end
      S_SEND: begin
        if (beat_ok && is_last) begin
          state_nxt = fifo_rd ? S_FETCH : S_IDLE;
        end
      end
      default: begin
        state_nxt = S_IDLE;
      end
    endcase
  end

  // A reset mid-word drops the partially sent word: the FIFO has already
  // been popped, so the data is simply lost rather than re-read.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      word_q     <= '0;
      idx        <= '0;
      word_count <= '0;
    end else begin
      state <= state_nxt;
      if (state == S_FETCH) begin
        word_q <= fifo_data;
        idx    <= '0;
      end
      if (beat_ok) begin
        if (is_last) begin
          word_count <= word_count + CNT_W'(1);
        end else begin
          idx <= idx + IDX_W'(1);
        end
      end
    end
  end

endmodule

// File: tb/tb_fifo_byte_serializer.sv
// Purpose : directed checks of fifo_byte_serializer in LSB-first and MSB-first builds.
// Latency : stimulus is driven 2 time units after each rising edge, outputs sampled 1 unit later.
// Backpr. : out_ready is driven directly by the stimulus sequence.
module tb_fifo_byte_serializer;

  logic        clk;
  logic        rst_n;
  logic        fifo_empty;
  logic [31:0] fifo_data;
  logic        out_ready;

  logic        rd0, vld0, last0, busy0;
  logic [7:0]  dat0;
  logic [15:0] wc0;
  logic        rd1, vld1, last1, busy1;
  logic [7:0]  dat1;
  logic [1:0]  wc1;

  int vectors;
  int miscompares;

  // LSB-first build with default counter width.
  fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(0), .CNT_W(16)) dut0 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd(rd0), .fifo_data(fifo_data),
    .out_data(dat0), .out_valid(vld0), .out_ready(out_ready), .out_last(last0),
    .busy(busy0), .word_count(wc0)
  );

  // MSB-first build with a 2-bit counter so wrap-around is reachable.
  fifo_byte_serializer #(.DATA_W(32), .BYTE_W(8), .MSB_FIRST(1), .CNT_W(2)) dut1 (
    .clk(clk), .rst_n(rst_n), .fifo_empty(fifo_empty), .fifo_rd(rd1), .fifo_data(fifo_data),
    .out_data(dat1), .out_valid(vld1), .out_ready(out_ready), .out_last(last1),
    .busy(busy1), .word_count(wc1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Advance to just after the next rising edge, ready to drive inputs.
  task automatic cyc();
    @(posedge clk);
    #2;
  endtask

  // Outputs common to both builds in a cycle without valid data.
  task automatic chk_quiet(input string tag, input logic exp_busy, input logic exp_rd);
    chk({tag, " valid0"}, vld0, 1'b0);
    chk({tag, " valid1"}, vld1, 1'b0);
    chk({tag, " last0"},  last0, 1'b0);
    chk({tag, " data0"},  dat0, 8'h00);
    chk({tag, " busy0"},  busy0, exp_busy);
    chk({tag, " busy1"},  busy1, exp_busy);
    chk({tag, " rd0"},    rd0, exp_rd);
    chk({tag, " rd1"},    rd1, exp_rd);
  endtask

  // FETCH cycle: drive the popped word, then expect a bubble.
  task automatic fetch(input string tag, input logic [31:0] w, input logic empty_after);
    cyc();
    fifo_data  = w;
    fifo_empty = empty_after;
    #1;
    chk_quiet({tag, " fetch"}, 1'b1, 1'b0);
  endtask

  // Four SEND cycles with out_ready = 1; exp_rd_last is the read strobe
  // expected alongside the last byte.
  task automatic send_word(input string tag, input logic [31:0] w, input logic exp_rd_last);
    for (int i = 0; i < 4; i++) begin
      cyc();
      out_ready = 1'b1;
      #1;
      chk($sformatf("%s b%0d valid0", tag, i), vld0, 1'b1);
      chk($sformatf("%s b%0d data0", tag, i), dat0, w[i*8 +: 8]);
      chk($sformatf("%s b%0d data1", tag, i), dat1, w[(3-i)*8 +: 8]);
      chk($sformatf("%s b%0d last0", tag, i), last0, (i == 3));
      chk($sformatf("%s b%0d last1", tag, i), last1, (i == 3));
      chk($sformatf("%s b%0d rd0", tag, i), rd0, (i == 3) ? exp_rd_last : 1'b0);
    end
  endtask

  initial begin
    logic [31:0] w;
    vectors     = 0;
    miscompares = 0;
    rst_n       = 1'b0;
    fifo_empty  = 1'b0;
    fifo_data   = 32'h0;
    out_ready   = 1'b1;

    // Reset held 3 cycles with a non-empty FIFO: everything quiet.
    for (int i = 0; i < 3; i++) begin
      cyc();
      #1;
      chk_quiet("reset", 1'b0, 1'b0);
      chk("reset wc0", wc0, 16'd0);
      chk("reset wc1", wc1, 2'd0);
    end

    // Release: read strobe in the first cycle with rst_n high.
    rst_n = 1'b1;
    #1;
    chk("release rd0", rd0, 1'b1);
    chk("release rd1", rd1, 1'b1);

    // Single word, FIFO then empty.
    w = 32'hA1B2C3D4;
    fetch("w1", w, 1'b1);
    send_word("w1", w, 1'b0);
    cyc();
    #1;
    chk_quiet("w1 idle", 1'b0, 1'b0);
    chk("w1 wc0", wc0, 16'd1);
    chk("w1 wc1", wc1, 2'd1);

    // Backpressure on byte 1; FIFO made non-empty during the stall.
    fifo_empty = 1'b0;
    #1;
    chk("bp rd0", rd0, 1'b1);
    fetch("bp", w, 1'b1);
    cyc();
    #1;
    chk("bp b0 data0", dat0, 8'hD4);
    for (int i = 0; i < 5; i++) begin
      cyc();
      out_ready  = 1'b0;
      fifo_empty = 1'b0;
      #1;
      chk($sformatf("bp stall%0d valid0", i), vld0, 1'b1);
      chk($sformatf("bp stall%0d data0", i), dat0, 8'hC3);
      chk($sformatf("bp stall%0d data1", i), dat1, 8'hB2);
      chk($sformatf("bp stall%0d rd0", i), rd0, 1'b0);
    end
    cyc();
    out_ready  = 1'b1;
    fifo_empty = 1'b1;
    #1;
    chk("bp b1 data0", dat0, 8'hC3);
    cyc();
    #1;
    chk("bp b2 data0", dat0, 8'hB2);
    cyc();
    #1;
    chk("bp b3 data0", dat0, 8'hA1);
    chk("bp b3 last0", last0, 1'b1);
    chk("bp b3 rd0", rd0, 1'b0);
    cyc();
    #1;
    chk_quiet("bp idle", 1'b0, 1'b0);
    chk("bp wc0", wc0, 16'd2);
    chk("bp wc1", wc1, 2'd2);

    // Streaming three words: FIFO non-empty until the third pop.
    fifo_empty = 1'b0;
    #1;
    chk("st rd0", rd0, 1'b1);
    fetch("st1", 32'h01020304, 1'b0);
    send_word("st1", 32'h01020304, 1'b1);
    fetch("st2", 32'h05060708, 1'b0);
    send_word("st2", 32'h05060708, 1'b1);
    fetch("st3", 32'h090A0B0C, 1'b1);
    send_word("st3", 32'h090A0B0C, 1'b0);
    cyc();
    #1;
    chk_quiet("st idle", 1'b0, 1'b0);
    chk("st wc0", wc0, 16'd5);
    chk("st wc1 wrap", wc1, 2'd1);

    // Reset while byte 2 of a word is on the output.
    fifo_empty = 1'b0;
    #1;
    chk("mr rd0", rd0, 1'b1);
    fetch("mr", 32'hDEADBEEF, 1'b1);
    cyc();
    #1;
    chk("mr b0 data0", dat0, 8'hEF);
    cyc();
    #1;
    chk("mr b1 data0", dat0, 8'hBE);
    cyc();
    rst_n      = 1'b0;
    fifo_empty = 1'b0;
    #1;
    chk("mr b2 data0", dat0, 8'hAD);
    chk("mr gated rd0", rd0, 1'b0);
    cyc();
    #1;
    chk_quiet("mr after", 1'b0, 1'b0);
    chk("mr wc0", wc0, 16'd0);
    chk("mr wc1", wc1, 2'd0);
    rst_n = 1'b1;
    #1;
    chk("mr release rd0", rd0, 1'b1);
    fetch("mr w", 32'h11223344, 1'b1);
    send_word("mr w", 32'h11223344, 1'b0);
    cyc();
    #1;
    chk_quiet("mr idle", 1'b0, 1'b0);
    chk("mr end wc0", wc0, 16'd1);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
